// File: rtl/dlatch_ex_pkg.sv
// Shared definitions for the d_latch exerciser: FSM encoding, step table and widths.
package dlatch_ex_pkg;

    localparam int STEP_W    = 3;
    localparam int NUM_STEPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit i holds the value for step s<i>; D sequence 0,0,1,1,0,1,1,0 and EN 0,1,1,0,0,0,1,1.
    localparam logic [NUM_STEPS-1:0] STEP_D_TABLE  = 8'b0110_1100;
    localparam logic [NUM_STEPS-1:0] STEP_EN_TABLE = 8'b1100_0110;

    localparam logic [STEP_W-1:0] FIRST_STEP = 3'd0;
    localparam logic [STEP_W-1:0] LAST_STEP  = 3'd7;

    // Value a transparent-high latch should present this cycle.
    function automatic logic latch_expect(input logic en, input logic d, input logic held);
        return en ? d : held;
    endfunction

endpackage

// File: rtl/dlatch_step_rom.sv
// Combinational lookup of the (D,EN) pair driven for each table step.
module dlatch_step_rom
    import dlatch_ex_pkg::*;
(
    input  logic [STEP_W-1:0] step_idx,
    output logic              d,
    output logic              en
);

    always_comb begin
        d  = STEP_D_TABLE[step_idx];
        en = STEP_EN_TABLE[step_idx];
    end

endmodule

// File: rtl/dlatch_exerciser.sv
// Walks a d_latch through the fixed step table, models the ideal latch alongside it
// and counts steps where Q/Qbar disagree with the model.
module dlatch_exerciser
    import dlatch_ex_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int PASSES      = 1,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              d_out,
    output logic              en_out,
    input  logic              q_in,
    input  logic              qbar_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [STEP_W-1:0] step,
    output logic [1:0]        dbg_state
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                exp_q, exp_d;
    logic                exp_valid_q, exp_valid_d;
    logic                d_out_q, d_out_d;
    logic                en_out_q, en_out_d;

    logic                rom_d, rom_en;
    logic                exp_now;
    logic                check_en;
    logic                check_fail;
    logic                drive_active;

    // The ROM looks at the next step so d_out/en_out/step change on the same edge.
    dlatch_step_rom u_rom (
        .step_idx (step_d),
        .d        (rom_d),
        .en       (rom_en)
    );

    always_comb begin
        exp_now    = latch_expect(en_out_q, d_out_q, exp_q);
        check_en   = en_out_q | exp_valid_q;
        check_fail = check_en & ((q_in != exp_now) | (qbar_in != ~q_in));
    end

    // Handshake: start is a request with no ready; it is accepted only while busy=0
    // (IDLE or DONE) and is ignored for the whole run, so a pulse mid-run is dropped.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        step_d      = step_q;
        pass_cnt_d  = pass_cnt_q;
        err_d       = err_q;
        exp_d       = exp_q;
        exp_valid_d = exp_valid_q;

        if (en_out_q) begin
            exp_d       = d_out_q;
            exp_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    hold_d      = '0;
                    step_d      = FIRST_STEP;
                    pass_cnt_d  = '0;
                    err_d       = '0;
                    exp_valid_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (check_fail && (err_q != ERR_MAX)) begin
                    err_d = err_q + 1'b1;
                end
                hold_d = '0;
                if (step_q == LAST_STEP) begin
                    if (pass_cnt_q == PASS_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_DRIVE;
                        step_d     = FIRST_STEP;
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DRIVE;
                    step_d  = step_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        drive_active = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
        d_out_d      = drive_active & rom_d;
        en_out_d     = drive_active & rom_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            step_q      <= '0;
            pass_cnt_q  <= '0;
            err_q       <= '0;
            exp_q       <= 1'b0;
            exp_valid_q <= 1'b0;
            d_out_q     <= 1'b0;
            en_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            pass_cnt_q  <= pass_cnt_d;
            err_q       <= err_d;
            exp_q       <= exp_d;
            exp_valid_q <= exp_valid_d;
            d_out_q     <= d_out_d;
            en_out_q    <= en_out_d;
        end
    end

    always_comb begin
        d_out     = d_out_q;
        en_out    = en_out_q;
        busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
        done      = (state_q == ST_DONE);
        pass      = (state_q == ST_DONE) && (err_q == '0);
        err_count = err_q;
        step      = step_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_dlatch_exerciser.sv
// Bench for dlatch_exerciser: a behavioural latch plus fault modes on the main instance,
// and two parameter variants (PASSES=2, ERR_W=2) wired to a stuck-0 latch.
module tb_dlatch_exerciser;

    localparam int H   = 4;
    localparam int RUN = 8 * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, start_p2, start_sat;
    int         mode;
    logic       rq, rqb;
    logic       lat_q;

    logic       d_out, en_out, q_in, qbar_in, busy, done, pass;
    logic [7:0] err_count;
    logic [2:0] step;
    logic [1:0] dbg_state;

    logic       d_p2, en_p2, busy_p2, done_p2, pass_p2;
    logic [7:0] err_p2;
    logic [2:0] step_p2;
    logic [1:0] dbg_p2;

    logic       d_sat, en_sat, busy_sat, done_sat, pass_sat;
    logic [1:0] err_sat;
    logic [2:0] step_sat;
    logic [1:0] dbg_sat;

    int checks = 0;
    int passed = 0;

    bit tbl_d[8]  = '{0, 0, 1, 1, 0, 1, 1, 0};
    bit tbl_en[8] = '{0, 1, 1, 0, 0, 0, 1, 1};

    // mode 0: ideal latch, 1: Q stuck at 0, 2: Qbar tied to Q, 3: random Q/Qbar
    always_latch begin
        if (en_out) lat_q = d_out;
    end
    assign q_in    = (mode == 3) ? rq : (mode == 1) ? 1'b0 : lat_q;
    assign qbar_in = (mode == 3) ? rqb : (mode == 1) ? 1'b1 : (mode == 2) ? q_in : ~lat_q;

    dlatch_exerciser #(.HOLD_CYCLES(H), .PASSES(1), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .d_out(d_out), .en_out(en_out),
        .q_in(q_in), .qbar_in(qbar_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .step(step), .dbg_state(dbg_state)
    );

    dlatch_exerciser #(.HOLD_CYCLES(H), .PASSES(2), .ERR_W(8)) dut_p2 (
        .clk(clk), .rst(rst), .start(start_p2), .d_out(d_p2), .en_out(en_p2),
        .q_in(1'b0), .qbar_in(1'b1), .busy(busy_p2), .done(done_p2), .pass(pass_p2),
        .err_count(err_p2), .step(step_p2), .dbg_state(dbg_p2)
    );

    dlatch_exerciser #(.HOLD_CYCLES(H), .PASSES(1), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_sat), .d_out(d_sat), .en_out(en_sat),
        .q_in(1'b0), .qbar_in(1'b1), .busy(busy_sat), .done(done_sat), .pass(pass_sat),
        .err_count(err_sat), .step(step_sat), .dbg_state(dbg_sat)
    );

    // Starts a run on the main instance and walks it cycle by cycle against the table.
    // seq_bad counts cycles where busy/done/step/d_out/en_out deviate; exp_err is the
    // error count the reference latch predicts. ign_at pulses start mid-run, abort_at
    // asserts reset at that cycle and returns early.
    task automatic run_main(input int ign_at, input int abort_at,
                            output int seq_bad, output int exp_err, output int err_at_abort);
        int  errs  = 0;
        bit  valid = 0;
        bit  val   = 0;
        seq_bad      = 0;
        exp_err      = 0;
        err_at_abort = -1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < RUN; i++) begin
            int s;
            s = i / H;
            if (i == abort_at) begin
                err_at_abort = int'(err_count);
                exp_err      = errs;
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            if (mode == 3) begin
                rq  = 1'($urandom);
                rqb = 1'($urandom);
                #1;
            end
            if (busy !== 1'b1 || done !== 1'b0 || step !== 3'(s) ||
                d_out !== tbl_d[s] || en_out !== tbl_en[s]) seq_bad++;
            if ((i % H) == H - 1 && (tbl_en[s] || valid)) begin
                bit e;
                e = tbl_en[s] ? tbl_d[s] : val;
                if (q_in !== e || qbar_in !== ~q_in) errs++;
            end
            if (tbl_en[s]) begin
                val   = tbl_d[s];
                valid = 1'b1;
            end
            if (i == ign_at) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        exp_err = (errs > 255) ? 255 : errs;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start_p2 = 1'b1; start_sat = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d_out !== 1'b0) $display("FAIL reset_d_out: got %b want 0", d_out); else passed++;
        checks++; if (en_out !== 1'b0) $display("FAIL reset_en_out: got %b want 0", en_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass); else passed++;
        checks++; if (err_count !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_count); else passed++;
        checks++; if (step !== 3'd0) $display("FAIL reset_step: got %0d want 0", step); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
        checks++; if (busy_p2 !== 1'b0 || busy_sat !== 1'b0)
            $display("FAIL reset_variants_busy: got %b%b want 00", busy_p2, busy_sat); else passed++;
        rst = 1'b0; start = 1'b0; start_p2 = 1'b0; start_sat = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ideal();
        int sb, ee, ea;
        mode = 0;
        run_main(-1, -1, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL ideal_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL ideal_done: got done=%b busy=%b want 1 0", done, busy); else passed++;
        checks++; if (err_count !== 8'(ee)) $display("FAIL ideal_err: got %0d want %0d", err_count, ee); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL ideal_pass: got %b want 1", pass); else passed++;
    endtask

    task automatic test_stuck0();
        int sb, ee, ea;
        mode = 1;
        run_main(-1, -1, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL stuck0_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (err_count !== 8'd5) $display("FAIL stuck0_err: got %0d want 5", err_count); else passed++;
        checks++; if (pass !== 1'b0 || done !== 1'b1)
            $display("FAIL stuck0_pass: got pass=%b done=%b want 0 1", pass, done); else passed++;
    endtask

    task automatic test_back_to_back();
        int sb, ee, ea;
        mode = 0;
        run_main(-1, -1, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL b2b_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (err_count !== 8'd0 || pass !== 1'b1)
            $display("FAIL b2b_result: got err=%0d pass=%b want 0 1", err_count, pass); else passed++;
    endtask

    task automatic test_broken_qbar();
        int sb, ee, ea;
        mode = 2;
        run_main(-1, -1, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL qbar_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (err_count !== 8'd7) $display("FAIL qbar_err: got %0d want 7", err_count); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL qbar_pass: got %b want 0", pass); else passed++;
    endtask

    task automatic test_passes2();
        int cyc = 0;
        start_p2 = 1'b1;
        @(posedge clk); #1 start_p2 = 1'b0;
        checks++; if (busy_p2 !== 1'b1) $display("FAIL p2_busy: got %b want 1", busy_p2); else passed++;
        while (done_p2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 2 * RUN) $display("FAIL p2_length: got %0d cycles want %0d", cyc, 2 * RUN); else passed++;
        checks++; if (err_p2 !== 8'd10) $display("FAIL p2_err: got %0d want 10", err_p2); else passed++;
        checks++; if (pass_p2 !== 1'b0) $display("FAIL p2_pass: got %b want 0", pass_p2); else passed++;
    endtask

    task automatic test_saturation();
        int cyc = 0;
        start_sat = 1'b1;
        @(posedge clk); #1 start_sat = 1'b0;
        while (done_sat !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== RUN) $display("FAIL sat_length: got %0d cycles want %0d", cyc, RUN); else passed++;
        checks++; if (err_sat !== 2'd3) $display("FAIL sat_err: got %0d want 3", err_sat); else passed++;
        checks++; if (pass_sat !== 1'b0) $display("FAIL sat_pass: got %b want 0", pass_sat); else passed++;
    endtask

    task automatic test_start_and_reset();
        int sb, ee, ea;
        int done_seen = 0;
        mode = 1;
        run_main(12, 20, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL abort_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (ea !== ee) $display("FAIL abort_err_before_rst: got %0d want %0d", ea, ee); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL abort_idle: got busy=%b done=%b state=%0d want 0 0 0", busy, done, dbg_state); else passed++;
        checks++; if (err_count !== 8'd0 || step !== 3'd0 || d_out !== 1'b0 || en_out !== 1'b0)
            $display("FAIL abort_outputs: got err=%0d step=%0d d=%b en=%b want all 0", err_count, step, d_out, en_out);
        else passed++;
        for (int i = 0; i < RUN + 4; i++) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        checks++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done cycles want 0", done_seen); else passed++;
        mode = 0;
        run_main(-1, -1, sb, ee, ea);
        checks++; if (sb !== 0) $display("FAIL rerun_sequence: got %0d bad cycles want 0", sb); else passed++;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0)
            $display("FAIL rerun_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); else passed++;
    endtask

    task automatic test_random();
        int sb, ee, ea;
        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            run_main(int'($urandom_range(0, RUN - 1)), -1, sb, ee, ea);
            checks++; if (sb !== 0) $display("FAIL rand%0d_sequence: got %0d bad cycles want 0 (mode %0d)", r, sb, mode);
            else passed++;
            checks++; if (err_count !== 8'(ee))
                $display("FAIL rand%0d_err: got %0d want %0d (mode %0d)", r, err_count, ee, mode); else passed++;
            checks++; if (done !== 1'b1 || pass !== (ee == 0))
                $display("FAIL rand%0d_pass: got done=%b pass=%b want 1 %b", r, done, pass, (ee == 0)); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_p2 = 1'b0; start_sat = 1'b0;
        mode = 0; rq = 1'b0; rqb = 1'b1;
        test_reset();
        test_ideal();
        test_stuck0();
        test_back_to_back();
        test_broken_qbar();
        test_passes2();
        test_saturation();
        test_start_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
